// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button input path (100 MHz board clock).
// Defaults: 10 ms debounce, 1 s long press, 200 ms auto-repeat.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 100_000_000;
  localparam int DEF_REPEAT_CYCLES   = 20_000_000;

  // Timing set is usable only if debounce is non-zero and shorter than a long press.
  function automatic bit cfg_ok(input int deb, input int lng, input int rpt);
    return (deb >= 1) && (lng > deb) && (rpt >= 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop sync, debounce FSM, long-press timer, registered event pulses.
// Press/release latency 2+DEBOUNCE_CYCLES; auto-repeat only when BUTTON_REPEAT_EN is defined.
module button_debounce
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
`ifdef BUTTON_REPEAT_EN
  , parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
  localparam logic [RW-1:0] DEB_R  = RW'(DEBOUNCE_CYCLES);
  localparam logic IDLE_PAD = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          s;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          press_nxt, release_nxt, long_nxt, held_nxt;

  always_ff @(posedge clk) begin
    if (rst) sync <= {2{IDLE_PAD}};
    else     sync <= {sync[0], btn_in};
  end

  assign s = sync[1] ^ IDLE_PAD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      rcnt          <= '0;
      held          <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rcnt          <= rcnt_nxt;
      held          <= held_nxt;
      press         <= press_nxt;
      release_pulse <= release_nxt;
      long_press    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rcnt_nxt    = rcnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    // Long timer keeps running through release bounces so they cannot shift long_press.
    if ((state == PRESSED || state == RELEASE_CHK) && cnt != LONG_C) begin
      cnt_nxt  = cnt + CW'(1);
      long_nxt = (cnt_nxt == LONG_C);
    end

    case (state)
      RELEASED: begin
        cnt_nxt  = '0;
        rcnt_nxt = '0;
        if (s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_C) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_CHK;
          rcnt_nxt  = RW'(1);
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_nxt = PRESSED;
          rcnt_nxt  = '0;
        end else if (rcnt == DEB_R) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          rcnt_nxt    = '0;
          release_nxt = 1'b1;
          long_nxt    = 1'b0;
        end else begin
          rcnt_nxt = rcnt + RW'(1);
        end
      end
      default: state_nxt = RELEASED;
    endcase

    held_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
  end

`ifdef BUTTON_REPEAT_EN
  localparam int PW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [PW-1:0] RPT_LAST = PW'(REPEAT_CYCLES - 1);

  logic [PW-1:0] rpt_cnt;

  // cnt parked at LONG_C while held means long_press has already fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if ((state == PRESSED || state == RELEASE_CHK) && cnt == LONG_C) begin
        if (rpt_cnt == RPT_LAST) begin
          rpt_cnt      <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + PW'(1);
        end
      end else begin
        rpt_cnt <= '0;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_events.sv
// N_BTN independent debounced button channels with press/release/long/repeat event pulses.
// Auto-repeat is built only when BUTTON_REPEAT_EN is defined; otherwise repeat_pulse is 0.
module button_events
  import button_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  // An unusable timing set yields a silent block instead of mis-timed events.
  if (cfg_ok(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_cfg
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_debounce #(
        .ACTIVE_LOW      (ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
`ifdef BUTTON_REPEAT_EN
        , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in[i]),
        .held          (held[i]),
        .press         (press[i]),
        .release_pulse (release_pulse[i]),
        .long_press    (long_press[i]),
        .repeat_pulse  (repeat_pulse[i])
      );
    end
  end else begin : g_bad_cfg
    assign held          = '0;
    assign press         = '0;
    assign release_pulse = '0;
    assign long_press    = '0;
    assign repeat_pulse  = '0;
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: debounce=4, long=20, repeat=5, active-low pads.
module tb_button_events;

`ifdef BUTTON_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] C0 = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] held, press, release_pulse, long_press, repeat_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  button_events #(
    .N_BTN           (2),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .REPEAT_CYCLES   (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .held          (held),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string sig, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s cyc=%0d observed=%b expected=%b", tag, sig, cyc, got, exp);
    end
  endtask

  // Advance one clock, then compare every output a little after the edge.
  task automatic tk(input string tag, input logic [1:0] eh, input logic [1:0] ep,
                    input logic [1:0] er, input logic [1:0] el, input logic [1:0] erp);
    @(posedge clk);
    #1;
    cyc++;
    chk(tag, "held", held, eh);
    chk(tag, "press", press, ep);
    chk(tag, "release", release_pulse, er);
    chk(tag, "long_press", long_press, el);
    chk(tag, "repeat", repeat_pulse, RPT ? erp : Z);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tk(tag, Z, Z, Z, Z, Z);
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) tk(tag, C0, Z, Z, Z, Z);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 2'b11;
    repeat (3) tk("reset", Z, Z, Z, Z, Z);
    rst = 1'b0;
    cyc = 0;

    // Clean press on ch0 at cycle 10; ch1 idle throughout.
    idle(9, "idle");                       // 1..9
    btn_in = 2'b10;
    idle(6, "press_wait");                 // 10..15
    tk("press", C0, C0, Z, Z, Z);          // 16
    hold(4, "held");                       // 17..20
    btn_in = 2'b11;                        // 2-cycle release bounce
    hold(2, "rel_bounce");                 // 21..22
    btn_in = 2'b10;
    hold(13, "held2");                     // 23..35
    tk("long", C0, Z, Z, C0, Z);           // 36 = press+20
    hold(4, "post_long");                  // 37..40
    tk("rpt1", C0, Z, Z, Z, C0);           // 41
    hold(4, "h");
    tk("rpt2", C0, Z, Z, Z, C0);           // 46
    hold(4, "h");
    tk("rpt3", C0, Z, Z, Z, C0);           // 51
    hold(4, "h");
    tk("rpt4", C0, Z, Z, Z, C0);           // 56
    btn_in = 2'b11;                        // pad released at 57
    hold(4, "rel_wait");                   // 57..60
    tk("rpt5", C0, Z, Z, Z, C0);           // 61, still in release check
    hold(1, "rel_wait2");                  // 62
    tk("release", Z, Z, C0, Z, Z);         // 63 = pad edge+6
    idle(5, "idle2");                      // 64..68

    // 3-cycle glitch: rejected.
    btn_in = 2'b10;
    idle(3, "glitch");                     // 69..71
    btn_in = 2'b11;
    idle(8, "glitch_after");               // 72..79

    // 6-cycle low pulse: exactly one press and one release.
    btn_in = 2'b10;
    idle(6, "pulse_wait");                 // 80..85
    btn_in = 2'b11;
    tk("pulse_press", C0, C0, Z, Z, Z);    // 86
    hold(5, "pulse_held");                 // 87..91
    tk("pulse_release", Z, Z, C0, Z, Z);   // 92
    idle(4, "idle3");                      // 93..96

    // Reset while pressed: no release, fresh press after reset.
    btn_in = 2'b10;
    idle(6, "rp_wait");                    // 97..102
    tk("rp_press", C0, C0, Z, Z, Z);       // 103
    hold(3, "rp_held");                    // 104..106
    rst = 1'b1;
    tk("rp_rst", Z, Z, Z, Z, Z);           // 107
    tk("rp_rst2", Z, Z, Z, Z, Z);          // 108
    rst = 1'b0;
    idle(6, "rp_after");                   // 109..114
    tk("rp_repress", C0, C0, Z, Z, Z);     // 115 = first free edge+6
    hold(2, "rp_held2");                   // 116..117
    btn_in = 2'b11;
    hold(6, "rp_rel_wait");                // 118..123
    tk("rp_release", Z, Z, C0, Z, Z);      // 124
    idle(3, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
